// File: rtl/seg7_capture_decoder_pkg.sv
// Shared definitions for the 7-segment capture decoder.
// Segment patterns are active-low with bit0 = segment a through bit6 = segment g.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h18;
  localparam logic [6:0] SEG_A    = 7'h08;
  localparam logic [6:0] SEG_B    = 7'h03;
  localparam logic [6:0] SEG_C    = 7'h46;
  localparam logic [6:0] SEG_D    = 7'h21;
  localparam logic [6:0] SEG_E    = 7'h06;
  localparam logic [6:0] SEG_F    = 7'h0E;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam int SEG_IDX_A = 0;
  localparam int SEG_IDX_B = 1;
  localparam int SEG_IDX_C = 2;
  localparam int SEG_IDX_D = 3;
  localparam int SEG_IDX_E = 4;
  localparam int SEG_IDX_F = 5;
  localparam int SEG_IDX_G = 6;

  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } frame_state_e;

endpackage

// File: rtl/seg7_capture_decoder_if.sv
// Frame output handshake for the 7-segment capture decoder.
// When SEG7_OVERRUN_EN is defined the bundle also carries the sticky overrun flag.
interface seg7_frame_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_ok;
  logic                    frame_valid;
  logic                    frame_ready;
`ifdef SEG7_OVERRUN_EN
  logic                    overrun;

  modport master (
    output value,
    output digit_ok,
    output frame_valid,
    output overrun,
    input  frame_ready
  );

  modport slave (
    input  value,
    input  digit_ok,
    input  frame_valid,
    input  overrun,
    output frame_ready
  );
`else
  modport master (
    output value,
    output digit_ok,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  value,
    input  digit_ok,
    input  frame_valid,
    output frame_ready
  );
`endif

endinterface

// File: rtl/seg7_capture_decoder_decode.sv
// Combinational lookup from an active-low 7-segment pattern back to its hex nibble.
// Anything that is not one of the sixteen hex glyphs (the dash included) reports ok=0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       ok,
  output logic [3:0] nibble
);

  // Table lookup, illegal glyphs fall through to nibble 0 with ok cleared
  always_comb begin
    ok     = 1'b1;
    nibble = 4'h0;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: begin
        ok     = 1'b0;
        nibble = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Captures a scanned active-low 7-segment bus, debounces each digit and assembles
// decoded hex frames presented over a valid/ready handshake.
// Define SEG7_OVERRUN_EN to add the sticky overrun flag on the frame interface.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] dig_sel,
  input  logic                  sample_en,
  seg7_frame_if.master          frm
);

  localparam int         IDXW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0]                  held_pat;
  logic [IDXW-1:0]             held_dig;
  logic [7:0]                  cnt;

  logic [IDXW-1:0]             sel_idx;
  logic                        qualified;
  logic                        bad_sel;
  logic                        match;
  logic                        commit;
  logic                        complete;
  logic                        dec_ok;
  logic [3:0]                  dec_nibble;

  logic [NUM_DIGITS-1:0][3:0]  slot_val;
  logic [NUM_DIGITS-1:0][3:0]  slot_val_next;
  logic [NUM_DIGITS-1:0]       slot_ok;
  logic [NUM_DIGITS-1:0]       slot_ok_next;
  logic [NUM_DIGITS-1:0]       seen;
  logic [NUM_DIGITS-1:0]       seen_next;

  logic [4*NUM_DIGITS-1:0]     value_q;
  logic [NUM_DIGITS-1:0]       ok_q;

  frame_state_e                state;
  frame_state_e                state_next;
  logic                        load_out;
`ifdef SEG7_OVERRUN_EN
  logic                        discard;
  logic                        overrun_q;
`endif

  seg7_pattern_decode u_decode (
    .pattern (seg_in),
    .ok      (dec_ok),
    .nibble  (dec_nibble)
  );

  // Encode the one-hot strobe to a digit index; only meaningful when the strobe is one-hot
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_sel[i]) sel_idx = IDXW'(i);
    end
  end

  // A zero counter means nothing is held, so a match needs a live count
  always_comb begin
    qualified = sample_en && $onehot(dig_sel);
    bad_sel   = sample_en && !$onehot(dig_sel);
    match     = (cnt != 8'd0) && (held_pat == seg_in) && (held_dig == sel_idx);
    commit    = qualified && match && (cnt == STABLE_LAST);
    complete  = commit && ((seen | dig_sel) == {NUM_DIGITS{1'b1}});
  end

  // Stability tracker: count repeats of the same pattern on the same digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_pat <= '0;
      held_dig <= '0;
      cnt      <= '0;
    end else if (bad_sel) begin
      cnt <= '0;
    end else if (qualified) begin
      if (match) begin
        if (cnt < STABLE_MAX) cnt <= cnt + 8'd1;
      end else begin
        held_pat <= seg_in;
        held_dig <= sel_idx;
        cnt      <= 8'd1;
      end
    end
  end

  // Working slots with the current commit merged in, so a completing commit reaches the output
  always_comb begin
    slot_val_next = slot_val;
    slot_ok_next  = slot_ok;
    seen_next     = seen;
    if (commit) begin
      slot_val_next[sel_idx] = dec_nibble;
      slot_ok_next[sel_idx]  = dec_ok;
      seen_next              = seen | dig_sel;
    end
    if (complete) seen_next = '0;
  end

  // Frame FSM next state: a completed frame in PENDING only loads if the consumer takes the old one
  always_comb begin
    state_next = state;
    load_out   = 1'b0;
`ifdef SEG7_OVERRUN_EN
    discard    = 1'b0;
`endif
    case (state)
      COLLECT: begin
        if (complete) begin
          state_next = PENDING;
          load_out   = 1'b1;
        end
      end
      PENDING: begin
        if (frm.frame_ready) begin
          if (complete) load_out = 1'b1;
          else          state_next = COLLECT;
        end else if (complete) begin
`ifdef SEG7_OVERRUN_EN
          discard = 1'b1;
`endif
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // Frame FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  // Working slots, seen mask and the output frame registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_val <= '0;
      slot_ok  <= '0;
      seen     <= '0;
      value_q  <= '0;
      ok_q     <= '0;
    end else begin
      slot_val <= slot_val_next;
      slot_ok  <= slot_ok_next;
      seen     <= seen_next;
      if (load_out) begin
        value_q <= slot_val_next;
        ok_q    <= slot_ok_next;
      end
    end
  end

`ifdef SEG7_OVERRUN_EN
  // Sticky overrun: set on a discarded frame, cleared when the consumer accepts a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       overrun_q <= 1'b0;
    else if (frm.frame_ready && (state == PENDING))   overrun_q <= 1'b0;
    else if (discard)                                 overrun_q <= 1'b1;
  end

  assign frm.overrun = overrun_q;
`endif

  assign frm.value       = value_q;
  assign frm.digit_ok    = ok_q;
  assign frm.frame_valid = (state == PENDING);

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder with NUM_DIGITS=4, STABLE_CYCLES=4.
// Overrun checks are included only when SEG7_OVERRUN_EN is defined.
module tb_seg7_capture_decoder;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [3:0] dig_sel;
  logic       sample_en;

  int vecCount;
  int errCount;

  seg7_frame_if #(.NUM_DIGITS(4)) frm ();

  seg7_capture_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .sample_en (sample_en),
    .frm       (frm)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one bus value for n cycles, inputs change 1 time unit after the rising edge
  task automatic applyStimulus(input logic [6:0] pat, input logic [3:0] sel, input logic en, input int n);
    for (int i = 0; i < n; i++) begin
      seg_in    = pat;
      dig_sel   = sel;
      sample_en = en;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic holdDigit(input int digit, input logic [6:0] pat);
    logic [3:0] sel;
    sel = 4'b0001 << digit;
    applyStimulus(pat, sel, 1'b1, 4);
  endtask

  task automatic pulseReady();
    frm.frame_ready = 1'b1;
    sample_en       = 1'b0;
    @(posedge clk);
    #1;
    frm.frame_ready = 1'b0;
  endtask

  task automatic resetPulse();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(frm.frame_valid), 32'h0);
    checkOutput("rst_value", 32'(frm.value), 32'h0);
    checkOutput("rst_ok", 32'(frm.digit_ok), 32'h0);
`ifdef SEG7_OVERRUN_EN
    checkOutput("rst_overrun", 32'(frm.overrun), 32'h0);
`endif
    #2 rst_n = 1'b1;
  endtask

  initial begin
    vecCount        = 0;
    errCount        = 0;
    rst_n           = 1'b0;
    seg_in          = 7'h7F;
    dig_sel         = 4'b0000;
    sample_en       = 1'b0;
    frm.frame_ready = 1'b0;

    @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(frm.frame_valid), 32'h0);
    checkOutput("reset_value", 32'(frm.value), 32'h0);
    checkOutput("reset_ok", 32'(frm.digit_ok), 32'h0);
    rst_n = 1'b1;

    // Basic frame 0123
    holdDigit(0, 7'h30);
    holdDigit(1, 7'h24);
    holdDigit(2, 7'h79);
    applyStimulus(7'h40, 4'b1000, 1'b1, 3);
    checkOutput("f1_not_yet", 32'(frm.frame_valid), 32'h0);
    applyStimulus(7'h40, 4'b1000, 1'b1, 1);
    checkOutput("f1_valid", 32'(frm.frame_valid), 32'h1);
    checkOutput("f1_value", 32'(frm.value), 32'h0123);
    checkOutput("f1_ok", 32'(frm.digit_ok), 32'hF);
    pulseReady();
    checkOutput("f1_drop", 32'(frm.frame_valid), 32'h0);

    // Illegal dash on digit 1
    holdDigit(0, 7'h40);
    holdDigit(1, 7'h3F);
    holdDigit(2, 7'h40);
    holdDigit(3, 7'h40);
    checkOutput("f2_valid", 32'(frm.frame_valid), 32'h1);
    checkOutput("f2_value", 32'(frm.value), 32'h0000);
    checkOutput("f2_ok", 32'(frm.digit_ok), 32'hD);
    pulseReady();

    // Pattern change restarts the count: 5 never commits, 6 does
    holdDigit(0, 7'h79);
    holdDigit(1, 7'h79);
    holdDigit(3, 7'h79);
    applyStimulus(7'h12, 4'b0100, 1'b1, 3);
    applyStimulus(7'h02, 4'b0100, 1'b1, 3);
    checkOutput("f3_no_commit", 32'(frm.frame_valid), 32'h0);
    applyStimulus(7'h02, 4'b0100, 1'b1, 1);
    checkOutput("f3_valid", 32'(frm.frame_valid), 32'h1);
    checkOutput("f3_value", 32'(frm.value), 32'h1611);
    pulseReady();

    // Non-one-hot strobe clears the count; disabled samples change nothing
    holdDigit(0, 7'h19);
    holdDigit(1, 7'h19);
    holdDigit(2, 7'h19);
    applyStimulus(7'h18, 4'b1000, 1'b1, 2);
    applyStimulus(7'h18, 4'b0011, 1'b1, 1);
    applyStimulus(7'h18, 4'b1000, 1'b1, 2);
    applyStimulus(7'h7F, 4'b0001, 1'b0, 2);
    applyStimulus(7'h18, 4'b1000, 1'b1, 1);
    checkOutput("f4_no_commit", 32'(frm.frame_valid), 32'h0);
    applyStimulus(7'h18, 4'b1000, 1'b1, 1);
    checkOutput("f4_valid", 32'(frm.frame_valid), 32'h1);
    checkOutput("f4_value", 32'(frm.value), 32'h9444);

    // Second frame completes while pending: discarded
    holdDigit(0, 7'h0E);
    holdDigit(1, 7'h0E);
    holdDigit(2, 7'h0E);
    holdDigit(3, 7'h0E);
    checkOutput("f5_valid", 32'(frm.frame_valid), 32'h1);
    checkOutput("f5_value_kept", 32'(frm.value), 32'h9444);
`ifdef SEG7_OVERRUN_EN
    checkOutput("f5_overrun", 32'(frm.overrun), 32'h1);
`endif

    // Third frame completes on the same cycle as ready: loads, valid stays high
    holdDigit(0, 7'h08);
    holdDigit(1, 7'h08);
    holdDigit(2, 7'h08);
    applyStimulus(7'h08, 4'b1000, 1'b1, 3);
    checkOutput("f6_value_kept", 32'(frm.value), 32'h9444);
    frm.frame_ready = 1'b1;
    applyStimulus(7'h08, 4'b1000, 1'b1, 1);
    frm.frame_ready = 1'b0;
    checkOutput("f6_valid", 32'(frm.frame_valid), 32'h1);
    checkOutput("f6_value", 32'(frm.value), 32'hAAAA);
`ifdef SEG7_OVERRUN_EN
    checkOutput("f6_overrun_clr", 32'(frm.overrun), 32'h0);
`endif
    applyStimulus(7'h7F, 4'b0000, 1'b0, 1);
    checkOutput("f6_still_valid", 32'(frm.frame_valid), 32'h1);

    // Reset while pending, then while collecting
    resetPulse();
    holdDigit(0, 7'h40);
    holdDigit(1, 7'h40);
    checkOutput("r1_partial", 32'(frm.frame_valid), 32'h0);
    resetPulse();
    holdDigit(2, 7'h79);
    holdDigit(3, 7'h79);
    checkOutput("r2_lost", 32'(frm.frame_valid), 32'h0);
    holdDigit(0, 7'h30);
    holdDigit(1, 7'h30);
    checkOutput("r2_valid", 32'(frm.frame_valid), 32'h1);
    checkOutput("r2_value", 32'(frm.value), 32'h1133);
    checkOutput("r2_ok", 32'(frm.digit_ok), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
- Reverse direction of the team's nibble-to-7-segment encoder.
- Samples a scanned, active-low 7-segment bus (pattern plus one-hot digit strobe) and debounces each digit's pattern.
- Decodes each pattern back to a 4-bit hex value and assembles a multi-digit frame.
- Presents the frame through a valid/ready handshake; used for display loopback self-test and for reading external 7-seg drivers on the DE2 board.

Parameters:
NUM_DIGITS, 4, number of scanned digits per frame (1..8)
STABLE_CYCLES, 4, consecutive identical qualified samples required before a digit commits (2..255)

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
SEG_IN  input  7  active-low segment pattern; bit0=a .. bit6=g
DIG_SEL  input  NUM_DIGITS  active-high one-hot digit strobe; bit i = digit i
SAMPLE_EN  input  1  qualifies SEG_IN/DIG_SEL this cycle
VALUE  output  4*NUM_DIGITS  decoded frame; nibble i = digit i
DIGIT_OK  output  NUM_DIGITS  per-digit legal-pattern flag for the frame on VALUE
FRAME_VALID  output  1  frame available
FRAME_READY  input  1  consumer accepts frame

Behaviour:
- Reset: one clock CLK; reset is asynchronous, active-low on RST_N. All outputs and internal registers clear to 0.
- Decode table (SEG_IN hex -> nibble):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 18->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
  - Any other pattern, including dash 3F, is illegal: nibble 0, ok=0.
- Stability tracker:
  - Holds last pattern, last digit index and a counter.
  - Qualified sample: SAMPLE_EN=1 and DIG_SEL exactly one-hot.
  - Qualified sample equal to held pattern+digit: counter increments, saturating at STABLE_CYCLES.
  - Differing qualified sample: load new pattern+digit, counter=1.
  - Non-one-hot DIG_SEL with SAMPLE_EN=1: counter cleared to 0, held pattern invalidated.
  - SAMPLE_EN=0: no change.
- Commit: on the cycle the counter reaches STABLE_CYCLES, the decoded nibble and ok bit are written into working slot[digit] and seen[digit] is set. A saturated counter never recommits. A digit committed twice within a frame is overwritten with the latest value.
- Frame FSM:
  - COLLECT: when seen becomes all-ones (including by the current commit) go to PENDING. On that transition the working slots, including the current commit, are copied to VALUE/DIGIT_OK and seen is cleared. FRAME_VALID=1 in the following cycle.
  - PENDING: VALUE and DIGIT_OK are held stable. FRAME_READY=1 returns to COLLECT, and FRAME_VALID drops the next cycle. Collection of the next frame continues while PENDING.
  - Next frame completes while PENDING without FRAME_READY: the pending frame is kept and the new frame is discarded (seen still cleared).
  - Next frame completes in the same cycle as FRAME_READY: the new frame loads and FRAME_VALID stays 1.
- Latency: last matching sample at cycle t -> commit at t+1 -> FRAME_VALID visible at t+1 if it completes the frame.
- Reset mid-frame: partial frame and any pending frame are lost.

Optional Feature:
- Macro: SEG7_OVERRUN_EN.
- Defined: adds output OVERRUN (1 bit), a sticky flag set when a completed frame is discarded in PENDING. Cleared only by reset or by FRAME_READY while FRAME_VALID=1.
- Undefined: no port; frames are discarded silently.

Decomposition:
- Package seg7_pkg:
  - Segment constants SEG_0..SEG_F and SEG_DASH (active-low, bit0=a).
  - Segment bit-index constants.
  - Frame FSM state encoding: COLLECT=0, PENDING=1.
- Sub-module seg7_pattern_decode: combinational 7-bit pattern -> {ok, nibble[3:0]} lookup, shared with the encoder's test bench.

Test Plan:
- NUM_DIGITS=4, STABLE_CYCLES=4; scan digits 0..3 with patterns 30,24,79,40, each held 4 qualified cycles -> VALUE=16'h0123, DIGIT_OK=4'hF, FRAME_VALID=1 one cycle after the digit-3 commit.
- Digit 1 pattern 3F held 4 cycles, others legal 0 -> DIGIT_OK=4'b1101, nibble 1 = 0.
- Digit 2 pattern 12 held 3 cycles, then 1 sample of 02, then 02 held 3 more -> no commit of 5; commit 6 after the 4th 02 sample.
- DIG_SEL=4'b0011 with SAMPLE_EN=1 mid-count -> counter cleared, no commit until 4 fresh samples.
- Frame pending with FRAME_READY=0, second frame completes -> VALUE unchanged, OVERRUN=1 (macro on). FRAME_READY=1 on the completion cycle of a third frame -> new VALUE loaded, FRAME_VALID stays high.
- Assert RST_N=0 mid-collect and mid-pending -> all outputs 0 immediately; first frame after release requires all 4 digits.
